buffer_sequencer: RTL and testbench
===================================

Name: buffer_sequencer

Overview:
- Sequences a single-port block RAM (the mining work buffer) through two phases: load DEPTH words from a streaming source, then stream them back out to the hash core.
- Sits between the loader, the BRAM and the hash core, and owns all BRAM address/write-enable generation.
- Read-out carries valid/ready backpressure and absorbs the BRAM's one-cycle read latency with a 2-entry output buffer, so full throughput is kept.

Parameters:
- ADDR_W, 9: BRAM address width.
- DATA_W, 32: word width.
- DEPTH, 512: words per job, 2..2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- abort  in  1  cancel the current job.
- wr_valid  in  1  loader word valid.
- wr_data  in  DATA_W  loader word.
- wr_ready  out  1  sequencer accepts a loader word.
- mem_we  out  1  BRAM write enable, registered.
- mem_addr  out  ADDR_W  BRAM address, registered.
- mem_wdata  out  DATA_W  BRAM write data, registered.
- mem_rdata  in  DATA_W  BRAM read data; valid 1 cycle after its address is presented.
- rd_valid  out  1  output word valid.
- rd_data  out  DATA_W  output word.
- rd_ready  in  1  hash core accepts the word.
- rd_last  out  1  qualifies the final word (address DEPTH-1).
- state  out  2  IDLE=00, WRITE=01, READ=10, DONE=11.
- busy  out  1  state is WRITE or READ.
- done  out  1  one-cycle pulse; high exactly while state==DONE.

Behaviour:
- Reset (reset==0 at a clock edge): every output goes to 0, state=IDLE, all counters and the buffer are cleared. Reset has priority over every other input.
- Priority below reset: abort, then all other inputs.
- IDLE:
  - start=1 and abort=0 → WRITE on the next cycle; write pointer wp=0.
  - start is ignored in all other states.
- WRITE:
  - wr_ready=1 unconditionally.
  - A beat is accepted when wr_valid & wr_ready. On the next cycle: mem_we=1, mem_addr=wp, mem_wdata=wr_data; wp increments.
  - Any cycle with no accepted beat drives mem_we=0 on the next cycle.
  - Accepting beat wp==DEPTH-1 → state=READ next cycle. wr_ready=0 from that cycle; the final write is presented in that same cycle.
- READ:
  - Read pointer rp starts at 0.
  - First read issue happens in the cycle after READ is entered, so it is registered one cycle after the final write. There is never a write/read collision.
  - A read is issued (mem_addr=rp, mem_we=0, rp++) when rp<DEPTH and (buffer occupancy + in-flight reads) <2, counting a word popped this cycle as freed.
  - Each returned mem_rdata is pushed into the 2-entry FIFO. rd_data/rd_valid come from the FIFO head.
  - While rd_valid=1 and rd_ready=0, rd_data is held stable.
  - With rd_ready held at 1, one word per cycle after a 2-cycle initial latency.
  - rd_last=1 with the word read from address DEPTH-1.
  - Handshake of the last word → DONE.
- DONE: lasts one cycle; done=1; then IDLE.
- abort in any non-IDLE state: IDLE next cycle. wr_ready, mem_we, rd_valid and rd_last go to 0, the FIFO and in-flight read are discarded, and no done pulse is produced. Written memory contents are not cleared.
- Counters never wrap. wp and rp saturate logic at DEPTH; no access beyond DEPTH-1 is ever issued.
- mem_addr holds its last value when idle; mem_we=0 outside accepted-write cycles.

Optional Feature:
- Macro MULTIPASS_EN.
- When defined:
  - Added parameter PASSES (default 2) and output pass_idx (ceil(log2(PASSES)) bits, reset 0).
  - READ streams the buffer PASSES times, addresses 0..DEPTH-1 each pass, back-to-back with no bubble between passes. rp wraps to 0 while pass_idx<PASSES-1.
  - rd_last is asserted on address DEPTH-1 of every pass.
  - DONE is entered only after the last word of pass PASSES-1.
  - pass_idx reflects the pass of the current rd_data.
- When not defined: single pass; no pass_idx port.

Test Plan:
- DEPTH=4, start, wr_data 0xA0..0xA3 on consecutive cycles, rd_ready=1:
  - writes to addr 0..3;
  - rd_data A0,A1,A2,A3 on 4 consecutive cycles, rd_last only with A3;
  - state 01→10→11→00, done high exactly 1 cycle.
- Loader gaps (wr_valid pattern 1,0,0,1,1,0,1) → exactly 4 mem_we pulses at addr 0..3; mem_we=0 in gap cycles.
- rd_ready pattern 1,0,0,1,0,1,1,… → sequence A0..A3 with no loss or duplication; rd_data stable on every stalled cycle; never more than 2 reads outstanding.
- abort asserted after 2 words handshaken in READ → next cycle state=00, rd_valid=0, done never pulses; a new start then replays A0..A3 correctly.
- reset=0 mid-WRITE (after wp=2) → next cycle all outputs 0, state=00; start held during busy is ignored (state unchanged).
- MULTIPASS_EN, PASSES=2, DEPTH=4 → A0..A3,A0..A3 back-to-back; rd_last twice; pass_idx 0 then 1; single done pulse.

Source files
------------

// File: rtl/buffer_sequencer.sv
// buffer_sequencer: drives a single-port BRAM through a load phase (DEPTH
// words from a streaming loader) and a read-out phase (words streamed to the
// hash core with valid/ready backpressure).
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-low reset
//   start, abort       job control (start only honoured in IDLE)
//   wr_valid/wr_data/wr_ready      loader stream in
//   mem_we/mem_addr/mem_wdata      registered BRAM controls
//   mem_rdata          BRAM read data, valid one cycle after mem_addr
//   rd_valid/rd_data/rd_ready/rd_last   stream out to the hash core
//   state, busy, done  status (IDLE=00 WRITE=01 READ=10 DONE=11)
//
// Optional build macro MULTIPASS_EN: adds parameter PASSES and output
// pass_idx; the buffer is streamed PASSES times back-to-back.
module buffer_sequencer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
`ifdef MULTIPASS_EN
  ,
  parameter int PASSES = 2
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              rd_last,
`ifdef MULTIPASS_EN
  output logic [((PASSES > 1) ? $clog2(PASSES) : 1)-1:0] pass_idx,
`endif
  output logic [1:0]        state,
  output logic              busy,
  output logic              done
);

`ifdef MULTIPASS_EN
  localparam int NPASS = PASSES;
`else
  localparam int NPASS = 1;
`endif
  localparam int PW = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam int CW = ADDR_W + 1;  // pointers must reach DEPTH to saturate
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_A  = CW'(DEPTH - 1);
  localparam logic [PW-1:0] LAST_P  = PW'(NPASS - 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_WRITE = 2'b01;
  localparam logic [1:0] S_READ  = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  typedef struct packed {
    logic          last;
    logic [PW-1:0] pass;
  } tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    tag_t              tag;
  } ent_t;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [PW-1:0]     ipass_q, ipass_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  // infl: address on the BRAM bus this cycle; rv: its data on mem_rdata now
  logic              infl_q, infl_d, rv_q, rv_d;
  tag_t              infl_tag_q, infl_tag_d, rv_tag_q, rv_tag_d;
  logic [1:0]        cnt_q, cnt_d;
  ent_t              e0_q, e0_d, e1_q, e1_d;

  ent_t       in_ent, head;
  logic       pop, issue;
  logic [2:0] occ;

  // Empty buffer falls through to mem_rdata so a freshly returned word can be
  // handshaken the cycle it arrives; that keeps the credit loop at 2 cycles.
  assign in_ent   = '{data: mem_rdata, tag: rv_tag_q};
  assign head     = (cnt_q != 2'd0) ? e0_q : in_ent;
  assign rd_valid = (state_q == S_READ) && ((cnt_q != 2'd0) || rv_q);
  assign rd_data  = rd_valid ? head.data : '0;
  assign rd_last  = rd_valid && head.tag.last;
  assign pop      = rd_valid && rd_ready;
`ifdef MULTIPASS_EN
  assign pass_idx = rd_valid ? head.tag.pass : '0;
`endif

  // Words buffered plus reads outstanding, with this cycle's pop already freed.
  assign occ   = {1'b0, cnt_q} + {2'b0, infl_q} + {2'b0, rv_q} - {2'b0, pop};
  assign issue = (state_q == S_READ) && !abort && (rp_q != DEPTH_C) && (occ < 3'd2);

  assign wr_ready  = (state_q == S_WRITE);
  assign busy      = (state_q == S_WRITE) || (state_q == S_READ);
  assign done      = (state_q == S_DONE);
  assign state     = state_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    ipass_d     = ipass_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    infl_d      = 1'b0;
    infl_tag_d  = infl_tag_q;
    rv_d        = infl_q;
    rv_tag_d    = infl_tag_q;
    cnt_d       = cnt_q;
    e0_d        = e0_q;
    e1_d        = e1_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_WRITE;
          wp_d    = '0;
          rp_d    = '0;
          ipass_d = '0;
        end
      end
      S_WRITE: begin
        if (wr_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wp_q[ADDR_W-1:0];
          mem_wdata_d = wr_data;
          wp_d        = wp_q + CW'(1);
          if (wp_q == LAST_A) state_d = S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          infl_d     = 1'b1;
          mem_addr_d = rp_q[ADDR_W-1:0];
          infl_tag_d = '{last: (rp_q == LAST_A), pass: ipass_q};
          if ((rp_q == LAST_A) && (ipass_q != LAST_P)) begin
            rp_d    = '0;
            ipass_d = ipass_q + PW'(1);
          end else begin
            rp_d = rp_q + CW'(1);
          end
        end
        if (pop && head.tag.last && (head.tag.pass == LAST_P)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Two-entry shift buffer; the credit check guarantees no push when full.
    case (cnt_q)
      2'd0: begin
        if (rv_q && !pop) begin
          e0_d  = in_ent;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (pop) begin
          if (rv_q) e0_d = in_ent;
          else      cnt_d = 2'd0;
        end else if (rv_q) begin
          e1_d  = in_ent;
          cnt_d = 2'd2;
        end
      end
      default: begin
        if (pop) begin
          e0_d = e1_q;
          if (rv_q) e1_d = in_ent;
          else      cnt_d = 2'd1;
        end
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      infl_d      = 1'b0;
      rv_d        = 1'b0;
      cnt_d       = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wp_q        <= '0;
      rp_q        <= '0;
      ipass_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      infl_q      <= 1'b0;
      infl_tag_q  <= '0;
      rv_q        <= 1'b0;
      rv_tag_q    <= '0;
      cnt_q       <= 2'd0;
      e0_q        <= '0;
      e1_q        <= '0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      ipass_q     <= ipass_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      infl_q      <= infl_d;
      infl_tag_q  <= infl_tag_d;
      rv_q        <= rv_d;
      rv_tag_q    <= rv_tag_d;
      cnt_q       <= cnt_d;
      e0_q        <= e0_d;
      e1_q        <= e1_d;
    end
  end

endmodule

// File: tb/tb_buffer_sequencer.sv
// Directed bench for buffer_sequencer (DEPTH=4, DATA_W=8) with a behavioural
// single-port BRAM. Cycle table for the basic job, then hand sequences for
// loader gaps, read stalls, abort and mid-job reset. Build with MULTIPASS_EN
// to also cover two-pass streaming.
module tb_buffer_sequencer;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
`ifdef MULTIPASS_EN
  localparam int NPASS = 2;
  logic [0:0] pass_idx;
`else
  localparam int NPASS = 1;
`endif
  localparam int NW = DEPTH * NPASS;

  logic clk, reset, start, abort, wr_valid, wr_ready, mem_we;
  logic rd_valid, rd_ready, rd_last, busy, done;
  logic [DATA_W-1:0] wr_data, mem_wdata, mem_rdata, rd_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  buffer_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
`ifdef MULTIPASS_EN
    , .PASSES(NPASS)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .rd_last(rd_last),
`ifdef MULTIPASS_EN
    .pass_idx(pass_idx),
`endif
    .state(state), .busy(busy), .done(done)
  );

  // Synchronous-read BRAM, read-before-write
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic [1:0]        st;
    logic              wrdy;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rv;
    logic [DATA_W-1:0] rdata;
    logic              rlast;
    logic              dn;
    logic              bsy;
  } obs_t;

  typedef struct {
    logic              start;
    logic              wv;
    logic [DATA_W-1:0] wd;
    logic              rr;
    obs_t              exp;
  } vec_t;

  vec_t tv [13];
  obs_t act;
  assign act = {state, wr_ready, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, rd_last, done, busy};

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load4();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hA0 + 8'(b);
      step();
    end
    wr_valid = 1'b0;
  endtask

  // Runs the read-out with a repeating 7-cycle rd_ready pattern and checks
  // order, rd_last, stall stability, outstanding reads and the done pulse.
  // stop_at > 0 returns right after that many handshakes.
  task automatic drain(input string nm, input logic [6:0] pat, input int stop_at);
    int idx = 0, issued = 0, maxo = 0, dones = 0, cyc = 0;
    logic stall = 1'b0, fin = 1'b0, started = 1'b0, bubble = 1'b0;
    logic [DATA_W-1:0] held = '0;
    logic [ADDR_W-1:0] pa = mem_addr;
    while (!fin && cyc < 200) begin
      rd_ready = pat[cyc % 7];
      @(negedge clk);
      if (stall) begin
        check({nm, "_stall_valid"}, 32'(rd_valid), 32'd1);
        check({nm, "_stall_data"}, 32'(rd_data), 32'(held));
      end
      if (mem_addr != pa && !mem_we && state == 2'b10) issued++;
      pa = mem_addr;
      if (issued - idx > maxo) maxo = issued - idx;
      if (started && !rd_valid && state == 2'b10) bubble = 1'b1;
      if (rd_valid) started = 1'b1;
      if (done) begin
        dones++;
        fin = 1'b1;
      end
      if (rd_valid && rd_ready) begin
        check({nm, "_data"}, 32'(rd_data), 32'(8'hA0 + 8'(idx % 4)));
        check({nm, "_last"}, 32'(rd_last), 32'(idx % 4 == 3));
`ifdef MULTIPASS_EN
        check({nm, "_pass"}, 32'(pass_idx), 32'(idx / 4));
`endif
        idx++;
        if (stop_at > 0 && idx == stop_at) fin = 1'b1;
      end
      stall = rd_valid && !rd_ready;
      held  = rd_data;
      step();
      cyc++;
    end
    check({nm, "_timeout"}, 32'(fin), 32'd1);
    check({nm, "_maxout"}, 32'(maxo <= 2), 32'd1);
    if (stop_at == 0) begin
      check({nm, "_count"}, 32'(idx), 32'(NW));
      check({nm, "_dones"}, 32'(dones), 32'd1);
      if (pat == 7'h7f) check({nm, "_bubble"}, 32'(bubble), 32'd0);
      @(negedge clk);
      check({nm, "_post_done"}, {30'd0, state}, {31'd0, done});
      step();
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; wr_valid = 1'b0;
    wr_data = '0; rd_ready = 1'b0;
    step(); step(); step();
    @(negedge clk);
    check("reset_state", 32'(act), 32'd0);
    step();
    reset = 1'b1;

`ifndef MULTIPASS_EN
    //        start wv  wd     rr   st wrdy we addr wdata rv  rdata rlast dn bsy
    tv[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, {2'd0,1'b0,1'b0,3'd0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0}};
    tv[1]  = '{1'b0, 1'b1, 8'hA0, 1'b1, {2'd1,1'b1,1'b0,3'd0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b1}};
    tv[2]  = '{1'b0, 1'b1, 8'hA1, 1'b1, {2'd1,1'b1,1'b1,3'd0,8'hA0,1'b0,8'h00,1'b0,1'b0,1'b1}};
    tv[3]  = '{1'b0, 1'b1, 8'hA2, 1'b1, {2'd1,1'b1,1'b1,3'd1,8'hA1,1'b0,8'h00,1'b0,1'b0,1'b1}};
    tv[4]  = '{1'b0, 1'b1, 8'hA3, 1'b1, {2'd1,1'b1,1'b1,3'd2,8'hA2,1'b0,8'h00,1'b0,1'b0,1'b1}};
    tv[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, {2'd2,1'b0,1'b1,3'd3,8'hA3,1'b0,8'h00,1'b0,1'b0,1'b1}};
    tv[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, {2'd2,1'b0,1'b0,3'd0,8'hA3,1'b0,8'h00,1'b0,1'b0,1'b1}};
    tv[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, {2'd2,1'b0,1'b0,3'd1,8'hA3,1'b1,8'hA0,1'b0,1'b0,1'b1}};
    tv[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, {2'd2,1'b0,1'b0,3'd2,8'hA3,1'b1,8'hA1,1'b0,1'b0,1'b1}};
    tv[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, {2'd2,1'b0,1'b0,3'd3,8'hA3,1'b1,8'hA2,1'b0,1'b0,1'b1}};
    tv[10] = '{1'b0, 1'b0, 8'h00, 1'b1, {2'd2,1'b0,1'b0,3'd3,8'hA3,1'b1,8'hA3,1'b1,1'b0,1'b1}};
    tv[11] = '{1'b0, 1'b0, 8'h00, 1'b1, {2'd3,1'b0,1'b0,3'd3,8'hA3,1'b0,8'h00,1'b0,1'b1,1'b0}};
    tv[12] = '{1'b0, 1'b0, 8'h00, 1'b1, {2'd0,1'b0,1'b0,3'd3,8'hA3,1'b0,8'h00,1'b0,1'b0,1'b0}};
    for (int i = 0; i < 13; i++) begin
      start = tv[i].start; wr_valid = tv[i].wv; wr_data = tv[i].wd; rd_ready = tv[i].rr;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(act), 32'(tv[i].exp));
      step();
    end
    start = 1'b0; wr_valid = 1'b0;
`else
    load4();
    drain("multipass", 7'h7f, 0);
`endif

    // Loader gaps: wr_valid 1,0,0,1,1,0,1
    begin
      logic [6:0] gp = 7'b1011001;
      int beats = 0;
      logic prev = 1'b0;
      rd_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
        wr_valid = gp[i];
        wr_data  = 8'hA0 + 8'(beats);
        @(negedge clk);
        check($sformatf("gap_we%0d", i), 32'(mem_we), 32'(prev));
        if (prev) check($sformatf("gap_addr%0d", i), 32'(mem_addr), 32'(beats - 1));
        if (gp[i]) beats++;
        prev = gp[i];
        step();
      end
      wr_valid = 1'b0;
      @(negedge clk);
      check("gap_we_end", 32'(mem_we), 32'd1);
      check("gap_addr_end", 32'(mem_addr), 32'd3);
      check("gap_state_end", 32'(state), 32'd2);
      step();
      drain("gap_read", 7'h7f, 0);
    end

    // Stalled read-out: rd_ready 1,0,0,1,0,1,1 repeating
    load4();
    drain("stall", 7'b1101001, 0);

    // Abort after two words handshaken, then replay
    load4();
    drain("pre_abort", 7'h7f, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("abort_state", 32'(state), 32'd0);
    check("abort_outs", {28'd0, rd_valid, rd_last, wr_ready, mem_we}, 32'd0);
    begin
      int dn = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        dn += int'(done);
      end
      check("abort_no_done", 32'(dn), 32'd0);
    end
    step();
    load4();
    drain("replay", 7'h7f, 0);

    // Reset mid-WRITE with start held high through the job
    start = 1'b1;
    step();
    for (int b = 0; b < 2; b++) begin
      wr_valid = 1'b1;
      wr_data  = 8'hA0 + 8'(b);
      @(negedge clk);
      check($sformatf("busy_start_ignored%0d", b), 32'(state), 32'd1);
      step();
    end
    wr_valid = 1'b0;
    reset = 1'b0;
    step();
    @(negedge clk);
    check("midreset_outs", 32'(act), 32'd0);
    step();
    reset = 1'b1;
    start = 1'b0;
    step();
    load4();
    drain("after_reset", 7'h7f, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
